// File: rtl/ram_sp_clr.sv
// ram_sp_clr: parametrised single-port synchronous RAM with a hardware clear sweep.
//
// After reset, or on a one-cycle clr request, the clear sequencer writes INIT_VAL into
// every location, one per cycle, while busy is high. Accesses are ignored while busy.
// Every accepted access reads the addressed word, and writes it if wren is high. Read
// data appears RD_LAT cycles later with a one-cycle q_valid pulse. q holds its last value
// while q_valid is low.
//
// Optional feature, macro RAM_PARITY_EN: each word carries an even-parity bit. Port
// parity_err flags a read whose data disagrees with its stored parity.
//
// Parameters:
//   DATA_W    data word width (>= 1)
//   ADDR_W    address width, DEPTH = 2**ADDR_W
//   RD_LAT    read latency, 1 or 2
//   RDW_NEW   read-during-write: 0 returns old contents, 1 returns the write data
//   INIT_VAL  value written by the clear sweep
//
// Ports:
//   clk         clock, all logic on posedge
//   rst_n       asynchronous active-low reset
//   clr         single-cycle request to start (or restart) the clear sweep
//   en          access strobe, accepted only when busy=0 and clr=0
//   wren        write enable, qualified by en
//   address     access address
//   data        write data
//   q           read data
//   q_valid     q holds data for an accepted access (one-cycle pulse per access)
//   busy        clear sweep in progress
//   parity_err  (RAM_PARITY_EN only) stored parity mismatch, valid with q_valid
module ram_sp_clr #(
    parameter int unsigned       DATA_W   = 4,
    parameter int unsigned       ADDR_W   = 4,
    parameter int unsigned       RD_LAT   = 1,
    parameter int unsigned       RDW_NEW  = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic              wren,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              busy
`ifdef RAM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
`ifdef RAM_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    // Stored word: data, plus its even-parity bit in the MSB when parity is enabled.
    function automatic logic [MEM_W-1:0] make_word(input logic [DATA_W-1:0] d);
`ifdef RAM_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    typedef enum logic [0:0] {
        StClear,
        StIdle
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              sweep_we;
    logic              accept;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  rd_word;

    logic [MEM_W-1:0]  s1_word_q;
    logic              s1_valid_q;
    logic [MEM_W-1:0]  out_word;
    logic              out_valid;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        sweep_we  = 1'b0;
        unique case (state_q)
            StClear: begin
                sweep_we  = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr) begin
                    // A new request restarts the sweep from the bottom.
                    clr_ptr_d = '0;
                end else if (&clr_ptr_q) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                if (clr) begin
                    state_d   = StClear;
                    clr_ptr_d = '0;
                end
            end
            default: begin
                state_d   = StClear;
                clr_ptr_d = '0;
            end
        endcase
    end

    assign busy   = (state_q == StClear);
    // clr wins over a same-cycle access.
    assign accept = en & ~busy & ~clr;

    // ------------------------------------------------------------------
    // Storage (contents are initialised by the sweep, not by reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem[clr_ptr_q] <= make_word(INIT_VAL);
        end else if (accept && wren) begin
            mem[address] <= make_word(data);
        end
    end

    always_comb begin
        rd_word = mem[address];
        if ((RDW_NEW != 0) && wren) begin
            rd_word = make_word(data);
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline; data registers only load on valid so q holds between reads.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_word_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_word_q <= rd_word;
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [MEM_W-1:0] s2_word_q;
        logic             s2_valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s2_word_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_word_q <= s1_word_q;
                end
            end
        end

        assign out_word  = s2_word_q;
        assign out_valid = s2_valid_q;
    end else begin : g_lat1
        assign out_word  = s1_word_q;
        assign out_valid = s1_valid_q;
    end

    assign q       = out_word[DATA_W-1:0];
    assign q_valid = out_valid;

`ifdef RAM_PARITY_EN
    assign parity_err = out_valid & ((^out_word[DATA_W-1:0]) != out_word[DATA_W]);
`endif

endmodule

// File: tb/tb_ram_sp_clr.sv
// tb_ram_sp_clr: self-checking bench for ram_sp_clr (default parameters).
// A behavioural model (array + read queue + sweep countdown) runs alongside the DUT;
// a compare process checks busy/q/q_valid every cycle, and directed scenarios add
// hand-computed literal checks. Build with +define+RAM_PARITY_EN for the parity test.
module tb_ram_sp_clr;

    localparam int DATA_W  = 4;
    localparam int ADDR_W  = 4;
    localparam int RD_LAT  = 1;
    localparam int RDW_NEW = 0;
    localparam int DEPTH   = 16;
    localparam int INIT    = 0;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              clr = 1'b0;
    logic              en = 1'b0;
    logic              wren = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [DATA_W-1:0] data = '0;
    logic [DATA_W-1:0] q;
    logic              q_valid;
    logic              busy;
`ifdef RAM_PARITY_EN
    logic              parity_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ram_sp_clr #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .RD_LAT  (RD_LAT),
        .RDW_NEW (RDW_NEW),
        .INIT_VAL(4'(INIT))
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .en        (en),
        .wren      (wren),
        .address   (address),
        .data      (data),
        .q         (q),
        .q_valid   (q_valid),
        .busy      (busy)
`ifdef RAM_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------
    int m_mem [DEPTH];
    bit m_bad [DEPTH];      // location whose stored parity was corrupted
    int sweep_left;         // cycles of clearing still to run
    bit pq_v [$];
    int pq_d [$];
    bit pq_b [$];
    int exp_q;
    bit exp_v;
    bit exp_pe;

    task automatic model_reset();
        sweep_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = INIT;
            m_bad[i] = 1'b0;
        end
        pq_v.delete();
        pq_d.delete();
        pq_b.delete();
        for (int i = 0; i < RD_LAT - 1; i++) begin
            pq_v.push_back(1'b0);
            pq_d.push_back(0);
            pq_b.push_back(1'b0);
        end
        exp_q  = 0;
        exp_v  = 1'b0;
        exp_pe = 1'b0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            bit busy_now, acc, v, b, rb;
            int rv, d;
            busy_now = (sweep_left > 0);
            acc      = en && !busy_now && !clr;
            if ((RDW_NEW != 0) && wren) begin
                rv = int'(data);
                rb = 1'b0;
            end else begin
                rv = m_mem[address];
                rb = m_bad[address];
            end
            if (acc && wren) begin
                m_mem[address] = int'(data);
                m_bad[address] = 1'b0;
            end
            pq_v.push_back(acc);
            pq_d.push_back(rv);
            pq_b.push_back(rb);
            v = pq_v.pop_front();
            d = pq_d.pop_front();
            b = pq_b.pop_front();
            exp_v  = v;
            exp_pe = v && b;
            if (v) exp_q = d;
            if (busy_now) begin
                sweep_left = clr ? DEPTH : sweep_left - 1;
            end else if (clr) begin
                // Nothing can access the array during a sweep, so clear it up front.
                sweep_left = DEPTH;
                for (int i = 0; i < DEPTH; i++) begin
                    m_mem[i] = INIT;
                    m_bad[i] = 1'b0;
                end
            end
        end
    end

    bit checking = 1'b0;

    always @(negedge clk) begin
        if (checking && rst_n) begin
            check("busy", int'(busy), int'(sweep_left > 0));
            check("q_valid", int'(q_valid), int'(exp_v));
            check("q", int'(q), exp_q);
`ifdef RAM_PARITY_EN
            check("parity_err", int'(parity_err), int'(exp_pe));
`endif
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic do_cyc(input bit e, input bit w, input int a, input int d, input bit c);
        @(negedge clk);
        en      = e;
        wren    = w;
        address = ADDR_W'(a);
        data    = DATA_W'(d);
        clr     = c;
    endtask

    // Counts busy cycles at negedges; pulses clr when the count reaches clr_at (0 = never).
    task automatic count_busy(input int clr_at, output int n, output bit saw_valid);
        n = 0;
        saw_valid = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            en  = 1'b0;
            clr = 1'b0;
            if (q_valid) saw_valid = 1'b1;
            if (!busy) return;
            n++;
            if (n == clr_at) clr = 1'b1;
        end
        check("busy_timeout", n, -1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        en  = 1'b0;
        clr = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_q", int'(q), 0);
        check("rst_q_valid", int'(q_valid), 0);
        check("rst_busy", int'(busy), 1);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bit sv;

        // 1: reset, sweep length, every address reads INIT_VAL
        #1 rst_n = 1'b0;
        #1;
        check("reset_q", int'(q), 0);
        check("reset_q_valid", int'(q_valid), 0);
        check("reset_busy", int'(busy), 1);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        checking = 1'b1;
        count_busy(0, n, sv);
        check("init_sweep_len", n, 16);
        for (int i = 0; i < DEPTH + RD_LAT; i++) begin
            @(negedge clk);
            if (i >= RD_LAT) begin
                check("init_read_q", int'(q), INIT);
                check("init_read_v", int'(q_valid), 1);
            end
            en      = (i < DEPTH);
            wren    = 1'b0;
            address = ADDR_W'(i);
        end

        // 2: write then read
        do_cyc(1, 1, 3, 'hA, 0);
        do_cyc(1, 0, 3, 0, 0);
        repeat (RD_LAT) do_cyc(0, 0, 0, 0, 0);
        check("wr_rd_q", int'(q), 'hA);
        check("wr_rd_v", int'(q_valid), 1);
        do_cyc(0, 0, 0, 0, 0);
        check("q_hold", int'(q), 'hA);
        check("v_pulse", int'(q_valid), 0);

        // 3: read-during-write
        do_cyc(1, 1, 5, 'h2, 0);
        do_cyc(1, 1, 5, 'h7, 0);
        repeat (RD_LAT) do_cyc(0, 0, 0, 0, 0);
        check("rdw_q", int'(q), (RDW_NEW != 0) ? 'h7 : 'h2);
        do_cyc(1, 0, 5, 0, 0);
        repeat (RD_LAT) do_cyc(0, 0, 0, 0, 0);
        check("rdw_after_q", int'(q), 'h7);

        // 4: clr beats a same-cycle write, then a sweep restart extends busy
        do_cyc(1, 1, 9, 'hF, 1);
        count_busy(0, n, sv);
        check("clr_sweep_len", n, 16);
        check("clr_drop_no_valid", int'(sv), 0);
        do_cyc(0, 0, 0, 0, 1);
        count_busy(8, n, sv);
        check("restart_sweep_len", n, 24);

        // 5: reset mid-sweep and mid-read
        do_cyc(0, 0, 0, 0, 1);
        repeat (5) @(negedge clk);
        clr = 1'b0;
        reset_pulse();
        count_busy(0, n, sv);
        check("rst_sweep_len", n, 16);
        do_cyc(1, 1, 4, 'hC, 0);
        do_cyc(1, 0, 4, 0, 0);
        reset_pulse();
        count_busy(0, n, sv);
        check("rst_read_sweep_len", n, 16);

`ifdef RAM_PARITY_EN
        // 6: corrupt one stored data bit and read it back
        do_cyc(1, 1, 6, 'hB, 0);
        do_cyc(1, 1, 7, 'h3, 0);
        do_cyc(0, 0, 0, 0, 0);
        dut.mem[6] = dut.mem[6] ^ 5'h01;
        m_mem[6]   = 'hA;
        m_bad[6]   = 1'b1;
        do_cyc(1, 0, 6, 0, 0);
        repeat (RD_LAT) do_cyc(0, 0, 0, 0, 0);
        check("par_err_bad", int'(parity_err), 1);
        check("par_err_v", int'(q_valid), 1);
        do_cyc(1, 0, 7, 0, 0);
        repeat (RD_LAT) do_cyc(0, 0, 0, 0, 0);
        check("par_err_good", int'(parity_err), 0);
`endif

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            do_cyc(($urandom_range(9, 0) < 7), $urandom_range(1, 0),
                   int'($urandom_range(DEPTH - 1, 0)), int'($urandom_range(15, 0)),
                   ($urandom_range(59, 0) == 0));
        end
        do_cyc(0, 0, 0, 0, 0);
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
